// File: rtl/ip_spi_cmd_pkg.sv
// Shared definitions for the SPI command responder: command codes, default
// acknowledge byte, FSM state encoding and the status byte layout.
package ip_spi_cmd_pkg;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hA5;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_CPU_RUN = 8'h02;
    localparam logic [7:0] CMD_KEY     = 8'h03;
    localparam logic [7:0] CMD_BANK_WR = 8'h04;
    localparam logic [7:0] CMD_STATUS  = 8'h05;
    localparam logic [7:0] CMD_CPU_RST = 8'h06;
    localparam logic [7:0] CMD_SLOT    = 8'h07;

    typedef enum logic [2:0] {
        S_CMD,
        S_KEY_Y,
        S_KEY_X,
        S_BANK,
        S_DATA,
        S_STAT,
        S_SLOT,
        S_IGNORE
    } state_e;

    function automatic logic [7:0] status_byte(input logic overrun, input logic busy);
        return {6'b0, overrun, busy};
    endfunction

endpackage

// File: rtl/ip_spi_slave_shifter.sv
// SPI mode-3 slave byte shifter: synchronizes the async SPI pins into clk,
// assembles MSB-first RX bytes and shifts TX bytes out on spi_clk falling edges.
module ip_spi_slave_shifter #(
    parameter logic [7:0] ACK_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       spi_cs_n,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] tx_byte,
    input  logic       tx_load,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       cs_active
);

    // Bit order in the synchronizer vectors: {cs_n, sclk, mosi}
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic       cs_prev_q;
    logic       sclk_prev_q;

    logic       cs_s;
    logic       sclk_s;
    logic       mosi_s;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_fall;

    logic [2:0] bit_cnt_q;
    logic [6:0] rx_shift_q;
    logic [7:0] rx_byte_q;
    logic       rx_done_q;
    logic [7:0] tx_shift_q;
    logic       miso_q;

    assign cs_s   = sync2_q[2];
    assign sclk_s = sync2_q[1];
    assign mosi_s = sync2_q[0];

    assign cs_active = ~cs_s;
    assign sclk_rise = cs_active & sclk_s & ~sclk_prev_q;
    assign sclk_fall = cs_active & ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            sync1_q     <= 3'b110;
            sync2_q     <= 3'b110;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            sync1_q     <= {spi_cs_n, spi_clk, spi_mosi};
            sync2_q     <= sync1_q;
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 7'd0;
            rx_byte_q  <= 8'd0;
            rx_done_q  <= 1'b0;
            tx_shift_q <= ACK_BYTE;
            miso_q     <= 1'b1;
        end else begin
            rx_done_q <= 1'b0;
            if (cs_s) begin
                // Deselect drops any partial byte and parks miso high
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b1;
            end else begin
                if (sclk_rise) begin
                    rx_shift_q <= {rx_shift_q[5:0], mosi_s};
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte_q <= {rx_shift_q, mosi_s};
                        rx_done_q <= 1'b1;
                    end
                end
                // Each falling edge presents tx_shift_q[7], so a freshly loaded
                // byte keeps its MSB on the line for the first edge of the byte.
                if (cs_fall) begin
                    tx_shift_q <= ACK_BYTE;
                    miso_q     <= ACK_BYTE[7];
                end else if (tx_load) begin
                    if (sclk_fall) begin
                        tx_shift_q <= {tx_byte[6:0], 1'b0};
                        miso_q     <= tx_byte[7];
                    end else begin
                        tx_shift_q <= tx_byte;
                    end
                end else if (sclk_fall) begin
                    tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                    miso_q     <= tx_shift_q[7];
                end
            end
        end
    end

    assign rx_byte  = rx_byte_q;
    assign rx_done  = rx_done_q;
    assign spi_miso = miso_q;

endmodule

// File: rtl/ip_spi_cmd_responder.sv
// Host-facing SPI command decoder: key matrix load, SDRAM bank streaming,
// status poll, slot configuration and CPU run/reset control.
module ip_spi_cmd_responder
    import ip_spi_cmd_pkg::*;
#(
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEFAULT,
    parameter int         OFFSET_W = 14,
    parameter int         BANK_W   = 8
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       spi_cs_n,
    input  logic                       spi_clk,
    input  logic                       spi_mosi,
    output logic                       spi_miso,
    output logic [3:0]                 key_y,
    output logic [7:0]                 key_x,
    output logic                       key_we,
    output logic [BANK_W+OFFSET_W-1:0] mem_address,
    output logic [7:0]                 mem_wdata,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    input  logic                       sdram_busy,
    output logic [7:0]                 slot_cfg,
    output logic                       cpu_reset_req,
    output logic                       cpu_run
);

    logic [7:0] rx_byte;
    logic       rx_done;
    logic       cs_active;
    logic       byte_ok;
    logic [7:0] tx_byte;
    logic       tx_load;

    state_e                     state_q;
    logic [BANK_W-1:0]          bank_q;
    logic [OFFSET_W-1:0]        offset_q;
    logic                       overrun_q;
    logic [3:0]                 key_y_q;
    logic [7:0]                 key_x_q;
    logic                       key_we_q;
    logic [BANK_W+OFFSET_W-1:0] mem_address_q;
    logic [7:0]                 mem_wdata_q;
    logic                       mem_valid_q;
    logic [7:0]                 slot_cfg_q;
    logic                       cpu_reset_req_q;
    logic                       cpu_run_q;

    ip_spi_slave_shifter #(
        .ACK_BYTE (ACK_BYTE)
    ) u_shifter (
        .clk       (clk),
        .n_reset   (n_reset),
        .spi_cs_n  (spi_cs_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .tx_byte   (tx_byte),
        .tx_load   (tx_load),
        .rx_byte   (rx_byte),
        .rx_done   (rx_done),
        .cs_active (cs_active)
    );

    // A byte finishing in the same cycle chip select drops is discarded
    assign byte_ok = rx_done & cs_active;
    assign tx_load = byte_ok;

    always_comb begin
        tx_byte = ACK_BYTE;
        if (state_q == S_CMD && rx_byte == CMD_STATUS) begin
            tx_byte = status_byte(overrun_q, sdram_busy);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q         <= S_CMD;
            bank_q          <= '0;
            offset_q        <= '0;
            overrun_q       <= 1'b0;
            key_y_q         <= 4'd0;
            key_x_q         <= 8'd0;
            key_we_q        <= 1'b0;
            mem_address_q   <= '0;
            mem_wdata_q     <= 8'd0;
            mem_valid_q     <= 1'b0;
            slot_cfg_q      <= 8'd0;
            cpu_reset_req_q <= 1'b0;
            cpu_run_q       <= 1'b0;
        end else begin
            key_we_q        <= 1'b0;
            cpu_reset_req_q <= 1'b0;
            if (mem_valid_q && mem_ready) begin
                mem_valid_q <= 1'b0;
            end
            if (!cs_active) begin
                state_q <= S_CMD;
            end else if (byte_ok) begin
                unique case (state_q)
                    S_CMD: begin
                        unique case (rx_byte)
                            CMD_NOP:     state_q <= S_CMD;
                            CMD_CPU_RUN: cpu_run_q <= 1'b1;
                            CMD_KEY:     state_q <= S_KEY_Y;
                            CMD_BANK_WR: state_q <= S_BANK;
                            CMD_STATUS:  state_q <= S_STAT;
                            CMD_CPU_RST: begin
                                cpu_reset_req_q <= 1'b1;
                                cpu_run_q       <= 1'b0;
                            end
                            CMD_SLOT:    state_q <= S_SLOT;
                            default:     state_q <= S_IGNORE;
                        endcase
                    end
                    S_KEY_Y: begin
                        key_y_q <= rx_byte[3:0];
                        state_q <= S_KEY_X;
                    end
                    S_KEY_X: begin
                        key_x_q  <= rx_byte;
                        key_we_q <= 1'b1;
                        state_q  <= S_CMD;
                    end
                    S_BANK: begin
                        bank_q   <= BANK_W'(rx_byte);
                        offset_q <= '0;
                        state_q  <= S_DATA;
                    end
                    S_DATA: begin
                        // Single-entry write buffer: a byte arriving while the
                        // previous write is still pending is lost and flagged.
                        if (mem_valid_q) begin
                            overrun_q <= 1'b1;
                        end else begin
                            mem_wdata_q   <= rx_byte;
                            mem_address_q <= {bank_q, offset_q};
                            mem_valid_q   <= 1'b1;
                            offset_q      <= offset_q + OFFSET_W'(1);
                        end
                    end
                    S_STAT: begin
                        overrun_q <= 1'b0;
                        state_q   <= S_CMD;
                    end
                    S_SLOT: begin
                        slot_cfg_q <= rx_byte;
                        state_q    <= S_CMD;
                    end
                    S_IGNORE: state_q <= S_IGNORE;
                    default:  state_q <= S_CMD;
                endcase
            end
        end
    end

    assign key_y         = key_y_q;
    assign key_x         = key_x_q;
    assign key_we        = key_we_q;
    assign mem_address   = mem_address_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_valid     = mem_valid_q;
    assign slot_cfg      = slot_cfg_q;
    assign cpu_reset_req = cpu_reset_req_q;
    assign cpu_run       = cpu_run_q;

endmodule

// File: tb/tb_ip_spi_cmd_responder.sv
// Self-checking bench: a bit-banged SPI master drives two responders (full
// 16 KiB banks and a 16-byte-bank variant that exposes the offset wrap).
module tb_ip_spi_cmd_responder;

    localparam int         HALF = 6;
    localparam logic [7:0] ACK  = 8'hA5;

    logic clk;
    logic n_reset;
    logic spi_cs_n;
    logic spi_clk;
    logic spi_mosi;
    logic mem_ready;
    logic sdram_busy;

    logic        spi_miso;
    logic [3:0]  key_y;
    logic [7:0]  key_x;
    logic        key_we;
    logic [21:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_valid;
    logic [7:0]  slot_cfg;
    logic        cpu_reset_req;
    logic        cpu_run;

    logic        miso_s;
    logic [3:0]  key_y_s;
    logic [7:0]  key_x_s;
    logic        key_we_s;
    logic [11:0] mem_address_s;
    logic [7:0]  mem_wdata_s;
    logic        mem_valid_s;
    logic [7:0]  slot_cfg_s;
    logic        cpu_reset_req_s;
    logic        cpu_run_s;

    int vecs = 0;
    int miscompares = 0;
    int ready_mode = 0;
    int key_we_cycles = 0;
    int rst_cycles = 0;

    logic [29:0] wq0[$];
    logic [29:0] eq0[$];
    logic [19:0] wq1[$];
    logic [19:0] eq1[$];

    logic [7:0] txb[0:63];
    logic [7:0] rxb[0:63];

    logic [3:0] m_ky;
    logic [7:0] m_kx;
    logic [7:0] m_slot;
    logic       m_run;

    ip_spi_cmd_responder dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .spi_cs_n      (spi_cs_n),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .key_y         (key_y),
        .key_x         (key_x),
        .key_we        (key_we),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .sdram_busy    (sdram_busy),
        .slot_cfg      (slot_cfg),
        .cpu_reset_req (cpu_reset_req),
        .cpu_run       (cpu_run)
    );

    ip_spi_cmd_responder #(
        .OFFSET_W (4)
    ) dut_s (
        .clk           (clk),
        .n_reset       (n_reset),
        .spi_cs_n      (spi_cs_n),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (miso_s),
        .key_y         (key_y_s),
        .key_x         (key_x_s),
        .key_we        (key_we_s),
        .mem_address   (mem_address_s),
        .mem_wdata     (mem_wdata_s),
        .mem_valid     (mem_valid_s),
        .mem_ready     (mem_ready),
        .sdram_busy    (sdram_busy),
        .slot_cfg      (slot_cfg_s),
        .cpu_reset_req (cpu_reset_req_s),
        .cpu_run       (cpu_run_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       mem_ready = 1'b0;
                1:       mem_ready = 1'b1;
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Handshakes and strobes are observed mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (key_we) key_we_cycles++;
            if (cpu_reset_req) rst_cycles++;
            if (mem_valid && mem_ready) wq0.push_back({mem_address, mem_wdata});
            if (mem_valid_s && mem_ready) wq1.push_back({mem_address_s, mem_wdata_s});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b > 7 - nbits; b--) begin
            spi_clk  = 1'b0;
            spi_mosi = tx[b];
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b1;
            rx = {rx[6:0], spi_miso};
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int n);
        logic [7:0] r;
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            spi_bits(txb[i], 8, r);
            rxb[i] = r;
        end
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic add_write(input logic [7:0] bank, input int idx, input logic [7:0] d);
        eq0.push_back({22'((int'(bank) << 14) + (idx % 16384)), d});
        eq1.push_back({12'((int'(bank) << 4) + (idx % 16)), d});
    endtask

    task automatic test_reset();
        n_reset = 1'b0; spi_cs_n = 1'b1; spi_clk = 1'b1; spi_mosi = 1'b0;
        sdram_busy = 1'b0; ready_mode = 1;
        repeat (4) @(negedge clk);
        vecs++;
        if ({spi_miso, key_we, key_y, key_x, mem_valid, mem_address, mem_wdata, slot_cfg, cpu_reset_req, cpu_run}
            !== {1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 22'h0, 8'h00, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got miso=%b kwe=%b ky=%h kx=%h mv=%b ma=%h md=%h slot=%h crr=%b run=%b, expected all reset values",
                     spi_miso, key_we, key_y, key_x, mem_valid, mem_address, mem_wdata, slot_cfg, cpu_reset_req, cpu_run);
        if ({spi_miso, key_we, key_y, key_x, mem_valid, mem_address, mem_wdata, slot_cfg, cpu_reset_req, cpu_run}
            !== {1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 22'h0, 8'h00, 8'h00, 1'b0, 1'b0}) miscompares++;
        n_reset = 1'b1;
        repeat (4) @(negedge clk);
        key_we_cycles = 0;
        txb[0] = 8'h00;
        send_frame(1);
        vecs++;
        if (rxb[0] !== ACK) begin
            miscompares++;
            $display("FAIL nop_response: got %h expected %h", rxb[0], ACK);
        end
        vecs++;
        if ({key_we_cycles != 0, key_y, key_x, mem_valid, slot_cfg, cpu_run} !== {1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL nop_no_effect: got kwe_cycles=%0d ky=%h kx=%h mv=%b slot=%h run=%b expected idle",
                     key_we_cycles, key_y, key_x, mem_valid, slot_cfg, cpu_run);
        end
        $display("reset + NOP frame: response %h", rxb[0]);
    endtask

    task automatic test_key();
        logic [7:0] y, x;
        for (int it = 0; it < 4; it++) begin
            y = (it == 0) ? 8'h05 : 8'($urandom);
            x = (it == 0) ? 8'h3C : 8'($urandom);
            key_we_cycles = 0;
            txb[0] = 8'h03; txb[1] = y; txb[2] = x;
            send_frame(3);
            vecs++;
            if ({rxb[0], rxb[1], rxb[2]} !== {ACK, ACK, ACK}) begin
                miscompares++;
                $display("FAIL key_resp: got %h %h %h expected all %h", rxb[0], rxb[1], rxb[2], ACK);
            end
            vecs++;
            if (key_we_cycles != 1) begin
                miscompares++;
                $display("FAIL key_we_width: got %0d cycles expected 1", key_we_cycles);
            end
            vecs++;
            if ({key_y, key_x} !== {y[3:0], x}) begin
                miscompares++;
                $display("FAIL key_value: got y=%h x=%h expected y=%h x=%h", key_y, key_x, y[3:0], x);
            end
            $display("key load: y=%h x=%h -> key_y=%h key_x=%h", y, x, key_y, key_x);
        end
        m_ky = y[3:0];
        m_kx = x;
    endtask

    task automatic test_bank_write();
        logic [7:0] bank, d;
        int n;
        for (int it = 0; it < 2; it++) begin
            wq0.delete(); wq1.delete(); eq0.delete(); eq1.delete();
            ready_mode = (it == 0) ? 1 : 2;
            bank = (it == 0) ? 8'h08 : 8'($urandom);
            n = (it == 0) ? 20 : 24;
            txb[0] = 8'h04; txb[1] = bank;
            for (int i = 0; i < n; i++) begin
                d = (i < 3 && it == 0) ? 8'(8'h11 * (i + 1)) : 8'($urandom);
                txb[2 + i] = d;
                add_write(bank, i, d);
            end
            send_frame(n + 2);
            ready_mode = 1;
            repeat (4) @(negedge clk);
            vecs++;
            if (wq0.size() != eq0.size() || wq1.size() != eq1.size()) begin
                miscompares++;
                $display("FAIL wr_count: got %0d/%0d expected %0d/%0d", wq0.size(), wq1.size(), eq0.size(), eq1.size());
            end
            for (int i = 0; i < eq0.size() && i < wq0.size(); i++) begin
                vecs++;
                if (wq0[i] !== eq0[i]) begin
                    miscompares++;
                    $display("FAIL wr_full[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                             i, wq0[i][29:8], wq0[i][7:0], eq0[i][29:8], eq0[i][7:0]);
                end
            end
            for (int i = 0; i < eq1.size() && i < wq1.size(); i++) begin
                vecs++;
                if (wq1[i] !== eq1[i]) begin
                    miscompares++;
                    $display("FAIL wr_wrap[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                             i, wq1[i][19:8], wq1[i][7:0], eq1[i][19:8], eq1[i][7:0]);
                end
            end
            $display("bank write: bank=%h bytes=%0d writes=%0d", bank, n, wq0.size());
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d0, d1;
        ready_mode = 0;
        repeat (2) @(negedge clk);
        wq0.delete(); wq1.delete();
        d0 = 8'($urandom); d1 = 8'($urandom);
        txb[0] = 8'h04; txb[1] = 8'h10; txb[2] = d0; txb[3] = d1;
        send_frame(4);
        vecs++;
        if ({mem_valid, mem_address, mem_wdata} !== {1'b1, 22'h040000, d0}) begin
            miscompares++;
            $display("FAIL pending_write: got mv=%b addr=%h data=%h expected mv=1 addr=040000 data=%h",
                     mem_valid, mem_address, mem_wdata, d0);
        end
        for (int p = 0; p < 2; p++) begin
            txb[0] = 8'h05; txb[1] = 8'h00;
            send_frame(2);
            vecs++;
            if ({rxb[0], rxb[1]} !== {ACK, (p == 0) ? 8'h02 : 8'h00}) begin
                miscompares++;
                $display("FAIL status_overrun[%0d]: got %h %h expected %h %h", p, rxb[0], rxb[1], ACK, (p == 0) ? 8'h02 : 8'h00);
            end
            $display("status poll %0d: %h", p, rxb[1]);
        end
        ready_mode = 1;
        repeat (4) @(negedge clk);
        vecs++;
        if (wq0.size() != 1 || mem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_drop: got %0d writes mv=%b expected 1 write mv=0", wq0.size(), mem_valid);
        end else begin
            vecs++;
            if (wq0[0] !== {22'h040000, d0}) begin
                miscompares++;
                $display("FAIL overrun_kept: got %h expected %h", wq0[0], {22'h040000, d0});
            end
        end
    endtask

    task automatic test_status_busy();
        sdram_busy = 1'b1;
        txb[0] = 8'h05; txb[1] = 8'h00;
        send_frame(2);
        vecs++;
        if (rxb[1] !== 8'h01) begin
            miscompares++;
            $display("FAIL status_busy: got %h expected 01", rxb[1]);
        end
        $display("status poll busy: %h", rxb[1]);
        sdram_busy = 1'b0;
    endtask

    task automatic test_abort();
        logic [7:0] s, r;
        s = 8'($urandom);
        txb[0] = 8'h07; txb[1] = s;
        send_frame(2);
        vecs++;
        if (slot_cfg !== s) begin
            miscompares++;
            $display("FAIL slot_write: got %h expected %h", slot_cfg, s);
        end
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h07, 4, r);
        spi_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        vecs++;
        if (slot_cfg !== s) begin
            miscompares++;
            $display("FAIL slot_abort: got %h expected %h", slot_cfg, s);
        end
        txb[0] = 8'h07; txb[1] = ~s;
        send_frame(2);
        vecs++;
        if (slot_cfg !== ~s) begin
            miscompares++;
            $display("FAIL fresh_frame: got %h expected %h", slot_cfg, ~s);
        end
        $display("slot: %h, aborted frame, then %h -> %h", s, ~s, slot_cfg);
    endtask

    task automatic test_cpu_and_reset();
        logic [7:0] r, d;
        rst_cycles = 0;
        txb[0] = 8'h06;
        send_frame(1);
        vecs++;
        if (rst_cycles != 1 || cpu_run !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_reset: got pulse_cycles=%0d run=%b expected 1 and 0", rst_cycles, cpu_run);
        end
        txb[0] = 8'h02;
        send_frame(1);
        vecs++;
        if (cpu_run !== 1'b1 || rst_cycles != 1) begin
            miscompares++;
            $display("FAIL cpu_run: got run=%b pulses=%0d expected 1 and 1", cpu_run, rst_cycles);
        end
        $display("cpu control: reset pulses=%0d run=%b", rst_cycles, cpu_run);
        ready_mode = 0;
        repeat (2) @(negedge clk);
        wq0.delete(); wq1.delete();
        d = 8'($urandom);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h04, 8, r);
        spi_bits(8'h22, 8, r);
        spi_bits(d, 8, r);
        spi_bits(8'hFF, 4, r);
        vecs++;
        if (mem_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_pending: got mv=%b expected 1", mem_valid);
        end
        n_reset = 1'b0;
        @(negedge clk);
        vecs++;
        if ({cpu_run, mem_valid, spi_miso} !== 3'b001) begin
            miscompares++;
            $display("FAIL mid_frame_reset: got run=%b mv=%b miso=%b expected 0 0 1", cpu_run, mem_valid, spi_miso);
        end
        n_reset = 1'b1;
        spi_cs_n = 1'b1;
        ready_mode = 1;
        repeat (2 * HALF) @(negedge clk);
        vecs++;
        if (wq0.size() != 0 || {key_y, key_x, slot_cfg} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_cleared: got writes=%0d ky=%h kx=%h slot=%h expected 0", wq0.size(), key_y, key_x, slot_cfg);
        end
        $display("mid-frame reset: run=%b mv=%b", cpu_run, mem_valid);
        m_ky = 4'h0; m_kx = 8'h00; m_slot = 8'h00; m_run = 1'b0;
    endtask

    task automatic test_random_frames();
        int op, n;
        logic [7:0] a, b, bank;
        for (int it = 0; it < 12; it++) begin
            op = $urandom_range(0, 4);
            a = 8'($urandom); b = 8'($urandom);
            wq0.delete(); wq1.delete(); eq0.delete(); eq1.delete();
            ready_mode = 2;
            n = 0;
            case (op)
                0: begin
                    txb[0] = 8'h03; txb[1] = a; txb[2] = b; n = 3;
                    m_ky = a[3:0]; m_kx = b;
                end
                1: begin
                    txb[0] = 8'h07; txb[1] = a; n = 2;
                    m_slot = a;
                end
                2: begin
                    txb[0] = a[0] ? 8'h02 : 8'h06; n = 1;
                    m_run = a[0];
                end
                3: begin
                    bank = a;
                    txb[0] = 8'h04; txb[1] = bank;
                    n = 2 + $urandom_range(1, 4);
                    for (int i = 2; i < n; i++) begin
                        txb[i] = 8'($urandom);
                        add_write(bank, i - 2, txb[i]);
                    end
                end
                default: begin
                    txb[0] = 8'($urandom_range(8, 255));
                    txb[1] = 8'h03; txb[2] = a; txb[3] = b; n = 4;
                end
            endcase
            send_frame(n);
            ready_mode = 1;
            repeat (4) @(negedge clk);
            vecs++;
            if ({key_y, key_x, slot_cfg, cpu_run} !== {m_ky, m_kx, m_slot, m_run}) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: got ky=%h kx=%h slot=%h run=%b expected ky=%h kx=%h slot=%h run=%b",
                         it, key_y, key_x, slot_cfg, cpu_run, m_ky, m_kx, m_slot, m_run);
            end
            vecs++;
            if (wq0 != eq0 || wq1 != eq1) begin
                miscompares++;
                $display("FAIL rand_writes[%0d]: got %0d/%0d writes expected %0d/%0d or data differs",
                         it, wq0.size(), wq1.size(), eq0.size(), eq1.size());
            end
            vecs++;
            if (rxb[n - 1] !== ACK) begin
                miscompares++;
                $display("FAIL rand_resp[%0d]: got %h expected %h", it, rxb[n - 1], ACK);
            end
            $display("random frame %0d: op=%0d bytes=%0d writes=%0d", it, op, n, wq0.size());
        end
    endtask

    initial begin
        n_reset = 1'b0; spi_cs_n = 1'b1; spi_clk = 1'b1; spi_mosi = 1'b0; sdram_busy = 1'b0;
        m_ky = 4'h0; m_kx = 8'h00; m_slot = 8'h00; m_run = 1'b0;
        test_reset();
        test_key();
        test_bank_write();
        test_overrun();
        test_status_busy();
        test_abort();
        test_cpu_and_reset();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
